// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: registered valid/ready slice with one skid entry.
// Every output, including in_ready, comes straight from a flop.
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_ready_q, out_valid_q;
    logic [1:0]       occ_q;
    logic             in_xfer, out_xfer;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
                FULL: if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    // Status flops are loaded from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= state_d != FULL;
            out_valid_q <= state_d != EMPTY;
            occ_q       <= state_d == FULL ? 2'd2 : state_d == ONE ? 2'd1 : 2'd0;
        end
    end
endmodule
